nx_mem_port_arbiter: RTL and testbench

- Shares one single-port table memory between a hardware datapath requester and the software indirect-access controller's memory port (sw_cs/sw_we/sw_add/sw_wdat, grant/yield).
- Hardware has priority by default. Software is protected from starvation by a consecutive-grant burst limit and by the controller's yield request.
- Routes read data back to the owner of each read and reports arbitration conflicts in a saturating counter.

---
 rtl/nx_mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_nx_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_mem_port_arbiter.sv
// Arbitrates a single-port table memory between a hw datapath and the sw indirect-access port.
// Hw wins by default; sw is protected by a consecutive-grant burst limit and by sw_yield.
module nx_mem_port_arbiter #(
  parameter int unsigned N_ADDR_BITS  = 9,
  parameter int unsigned N_DATA_BITS  = 96,
  parameter int unsigned HW_BURST_MAX = 8,
  parameter int unsigned N_CNT_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   hw_req,
  input  logic                   hw_we,
  input  logic [N_ADDR_BITS-1:0] hw_addr,
  input  logic [N_DATA_BITS-1:0] hw_wdat,
  output logic                   hw_gnt,
  output logic                   hw_rvld,
  output logic [N_DATA_BITS-1:0] hw_rdat,
  input  logic                   sw_cs,
  input  logic                   sw_we,
  input  logic [N_ADDR_BITS-1:0] sw_add,
  input  logic [N_DATA_BITS-1:0] sw_wdat,
  input  logic                   sw_yield,
  output logic                   sw_grant,
  output logic [N_DATA_BITS-1:0] sw_rdat,
  output logic                   mem_cs,
  output logic                   mem_we,
  output logic [N_ADDR_BITS-1:0] mem_addr,
  output logic [N_DATA_BITS-1:0] mem_wdat,
  input  logic [N_DATA_BITS-1:0] mem_rdat,
  output logic [N_CNT_BITS-1:0]  conflict_cnt
);

  typedef enum logic {StHwPri, StSwPri} state_e;

  localparam logic [7:0] BurstLast = 8'(HW_BURST_MAX - 1);

  state_e                r_state;
  logic [7:0]            r_burst;
  logic                  r_hw_rvld;
  logic [N_CNT_BITS-1:0] r_conflict_cnt;

  logic w_hw_eff;
  logic w_hw_gnt;
  logic w_sw_grant;

  // Grants are forced low while reset is held so the memory sees no stray access.
  always_comb begin
    w_hw_eff   = hw_req & enable;
    w_hw_gnt   = 1'b0;
    w_sw_grant = 1'b0;
    if (!rst) begin
      case (r_state)
        StHwPri: begin
          w_sw_grant = sw_cs & (~w_hw_eff | sw_yield);
          w_hw_gnt   = w_hw_eff & ~w_sw_grant;
        end
        StSwPri: begin
          w_sw_grant = sw_cs;
          w_hw_gnt   = w_hw_eff & ~sw_cs;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StHwPri;
      r_burst        <= '0;
      r_hw_rvld      <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_hw_rvld <= w_hw_gnt & ~hw_we;
      if (sw_cs && w_hw_eff && !(&r_conflict_cnt)) begin
        r_conflict_cnt <= r_conflict_cnt + N_CNT_BITS'(1);
      end
      case (r_state)
        StHwPri: begin
          if (w_hw_gnt && sw_cs && r_burst == BurstLast) begin
            r_state <= StSwPri;
            r_burst <= '0;
          end else if (w_sw_grant || !sw_cs) begin
            r_burst <= '0;
          end else if (w_hw_gnt) begin
            r_burst <= r_burst + 8'd1;
          end
        end
        StSwPri: begin
          r_burst <= '0;
          if (w_sw_grant || !sw_cs) r_state <= StHwPri;
        end
        default: begin
          r_state <= StHwPri;
          r_burst <= '0;
        end
      endcase
    end
  end

  always_comb begin
    hw_gnt       = w_hw_gnt;
    sw_grant     = w_sw_grant;
    hw_rvld      = r_hw_rvld;
    conflict_cnt = r_conflict_cnt;
    mem_cs       = w_hw_gnt | w_sw_grant;
    mem_we       = w_hw_gnt ? hw_we : (w_sw_grant & sw_we);
    mem_addr     = w_hw_gnt ? hw_addr : sw_add;
    mem_wdat     = w_hw_gnt ? hw_wdat : sw_wdat;
    hw_rdat      = mem_rdat;
    sw_rdat      = mem_rdat;
  end

endmodule

// File: tb/tb_nx_mem_port_arbiter.sv
// Bench for nx_mem_port_arbiter: constant vector table, hand-written corner sequences and a
// randomized run against a priority/streak reference model with a shadow memory.
module tb_nx_mem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 96;
  localparam int BM = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          hw_req = 1'b0;
  logic          hw_we = 1'b0;
  logic [AW-1:0] hw_addr = '0;
  logic [DW-1:0] hw_wdat = '0;
  logic          sw_cs = 1'b0;
  logic          sw_we = 1'b0;
  logic [AW-1:0] sw_add = '0;
  logic [DW-1:0] sw_wdat = '0;
  logic          sw_yield = 1'b0;
  logic [DW-1:0] mem_rdat;

  logic          hw_gnt, hw_rvld, sw_grant, mem_cs, mem_we;
  logic [DW-1:0] hw_rdat, sw_rdat, mem_wdat;
  logic [AW-1:0] mem_addr;
  logic [15:0]   conflict_cnt;

  logic          b_hw_gnt, b_hw_rvld, b_sw_grant, b_mem_cs, b_mem_we;
  logic [DW-1:0] b_hw_rdat, b_sw_rdat, b_mem_wdat;
  logic [AW-1:0] b_mem_addr;
  logic [3:0]    b_conflict_cnt;

  always #5 clk = ~clk;

  nx_mem_port_arbiter #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .HW_BURST_MAX(BM), .N_CNT_BITS(16))
  u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdat(hw_wdat),
    .hw_gnt(hw_gnt), .hw_rvld(hw_rvld), .hw_rdat(hw_rdat),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_yield(sw_yield),
    .sw_grant(sw_grant), .sw_rdat(sw_rdat),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .conflict_cnt(conflict_cnt)
  );

  // Same stimulus into a 4-bit-counter instance to observe saturation.
  nx_mem_port_arbiter #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .HW_BURST_MAX(BM), .N_CNT_BITS(4))
  u_dut4 (
    .clk(clk), .rst(rst), .enable(enable),
    .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdat(hw_wdat),
    .hw_gnt(b_hw_gnt), .hw_rvld(b_hw_rvld), .hw_rdat(b_hw_rdat),
    .sw_cs(sw_cs), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_yield(sw_yield),
    .sw_grant(b_sw_grant), .sw_rdat(b_sw_rdat),
    .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdat(b_mem_wdat),
    .mem_rdat(mem_rdat), .conflict_cnt(b_conflict_cnt)
  );

  // Single-port memory with 1-cycle read latency, driven by the main instance.
  logic [DW-1:0] mem [512];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr] <= mem_wdat;
      else        mem_rdat <= mem[mem_addr];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [512];
  int            m_streak, m_cnt;
  bit            m_forced, m_hw_pend, m_sw_pend;
  logic [DW-1:0] m_hw_data, m_sw_data;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit en, input bit hreq, input bit hwe,
                       input bit scs, input bit swe, input bit yld);
    rst = r; enable = en; hw_req = hreq; hw_we = hwe;
    sw_cs = scs; sw_we = swe; sw_yield = yld;
    hw_addr = AW'($urandom);
    sw_add  = AW'($urandom);
    hw_wdat = {$urandom, $urandom, $urandom};
    sw_wdat = {$urandom, $urandom, $urandom};
  endtask

  // Checks every output against the model, then advances the model and time by one clock.
  task automatic tick();
    bit            hw_eff, e_sw, e_hw, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat;
    int            sat16, sat4;
    #3;
    if (rst) begin
      m_streak = 0; m_cnt = 0; m_forced = 0; m_hw_pend = 0; m_sw_pend = 0;
    end
    hw_eff = hw_req & enable;
    e_sw   = !rst && sw_cs && (!hw_eff || sw_yield || m_forced);
    e_hw   = !rst && hw_eff && !e_sw;
    e_we   = e_hw ? hw_we : (e_sw && sw_we);
    e_addr = e_hw ? hw_addr : sw_add;
    e_wdat = e_hw ? hw_wdat : sw_wdat;
    sat16  = (m_cnt > 65535) ? 65535 : m_cnt;
    sat4   = (m_cnt > 15) ? 15 : m_cnt;
    chk("grants", {hw_gnt, sw_grant, mem_cs, mem_we}, {e_hw, e_sw, e_hw | e_sw, e_we});
    chk("grants_cnt4", {b_hw_gnt, b_sw_grant, b_mem_cs, b_mem_we}, {e_hw, e_sw, e_hw | e_sw, e_we});
    chk("mem_addr", {mem_addr, b_mem_addr}, {e_addr, e_addr});
    chk("mem_wdat", mem_wdat, e_wdat);
    chk("mem_wdat_cnt4", b_mem_wdat, e_wdat);
    chk("hw_rvld", {hw_rvld, b_hw_rvld}, {m_hw_pend, m_hw_pend});
    chk("conflict_cnt", conflict_cnt, sat16);
    chk("conflict_cnt4", b_conflict_cnt, sat4);
    if (m_hw_pend) begin
      chk("hw_rdat", hw_rdat, m_hw_data);
      chk("hw_rdat_cnt4", b_hw_rdat, m_hw_data);
    end
    if (m_sw_pend) begin
      chk("sw_rdat", sw_rdat, m_sw_data);
      chk("sw_rdat_cnt4", b_sw_rdat, m_sw_data);
    end
    if (!rst) begin
      m_hw_pend = e_hw && !hw_we;
      m_sw_pend = e_sw && !sw_we;
      m_hw_data = ref_mem[hw_addr];
      m_sw_data = ref_mem[sw_add];
      if (e_hw && hw_we) ref_mem[hw_addr] = hw_wdat;
      if (e_sw && sw_we) ref_mem[sw_add] = sw_wdat;
      if (sw_cs && hw_eff) m_cnt++;
      // sw is owed one access after BM hw grants in a row while it waits.
      if (e_sw || !sw_cs) begin
        m_streak = 0; m_forced = 0;
      end else if (e_hw) begin
        m_streak++;
        if (m_streak == BM) begin
          m_streak = 0; m_forced = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit en, hreq, hwe, scs, swe, yld;
    bit e_hw, e_sw, e_we;
  } vec_t;

  vec_t vecs [9];
  int   sw_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{1, 1, 1, 0, 0, 0, 1, 0, 1};
    vecs[2] = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
    vecs[3] = '{1, 1, 0, 1, 0, 0, 1, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
    vecs[5] = '{0, 1, 1, 1, 0, 0, 0, 1, 0};
    vecs[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[8] = '{1, 0, 1, 0, 1, 0, 0, 0, 0};

    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    #2 chk("reset_state", {hw_gnt, sw_grant, mem_cs, mem_we, hw_rvld, conflict_cnt}, '0);
    tick();

    // Controller init sweep while disabled; also initialises every memory word.
    sw_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      drive(0, 0, 1, 0, 1, 1, 0);
      sw_add = AW'(i);
      #2 if (sw_grant && !hw_gnt) sw_cnt++;
      tick();
    end
    chk("sweep_sw_grants", sw_cnt, 512);
    chk("sweep_conflicts", conflict_cnt, 0);

    foreach (vecs[i]) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, vecs[i].en, vecs[i].hreq, vecs[i].hwe, vecs[i].scs, vecs[i].swe, vecs[i].yld);
      #2 chk($sformatf("vec%0d", i), {hw_gnt, sw_grant, mem_cs, mem_we},
             {vecs[i].e_hw, vecs[i].e_sw, vecs[i].e_hw | vecs[i].e_sw, vecs[i].e_we});
      tick();
    end

    // Sw read of 0x1A5 with no hw traffic.
    drive(0, 1, 0, 0, 1, 0, 0);
    sw_add = 9'h1A5;
    #2 chk("sw_read_grant", {sw_grant, hw_gnt, mem_addr, mem_we}, {1'b1, 1'b0, 9'h1A5, 1'b0});
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #2 chk("sw_read_data", {hw_rvld, sw_rdat}, {1'b0, ref_mem[9'h1A5]});
    tick();

    // Continuous contention: 8 hw grants then 1 sw grant, repeating.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 18; k++) begin
      drive(0, 1, 1, 0, 1, 0, 0);
      #2 chk($sformatf("burst_c%0d", k), {hw_gnt, sw_grant}, {k % 9 != 8, k % 9 == 8});
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    #2 chk("burst_conflicts", conflict_cnt, 18);
    tick();

    // Yield after 3 hw grants; the burst count must restart from zero.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 13; k++) begin
      drive(0, 1, 1, 1, 1, 0, k == 3);
      #2 chk($sformatf("yield_c%0d", k), {hw_gnt, sw_grant},
             {k != 3 && k != 12, k == 3 || k == 12});
      tick();
    end

    // Back-to-back hw reads, then a hw write.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0);
    hw_addr = 9'd5;
    #2 chk("hwrd_c0", {hw_gnt, hw_rvld}, 2'b10);
    tick();
    drive(0, 1, 1, 0, 0, 0, 0);
    hw_addr = 9'd6;
    #2 chk("hwrd_c1", {hw_gnt, hw_rvld, hw_rdat}, {2'b11, ref_mem[5]});
    tick();
    drive(0, 1, 1, 1, 0, 0, 0);
    hw_addr = 9'd7;
    #2 chk("hwrd_c2", {hw_gnt, hw_rvld, hw_rdat}, {2'b11, ref_mem[6]});
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    #2 chk("hwrd_c3", hw_rvld, 1'b0);
    tick();

    // Saturation, then reset right after a hw read grant.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 1, 1, 1, 1, 0);
      tick();
    end
    drive(0, 1, 1, 0, 0, 0, 0);
    #2 chk("sat_before_rst", {b_conflict_cnt, conflict_cnt, hw_gnt}, {4'd15, 16'd20, 1'b1});
    tick();
    drive(1, 1, 1, 0, 1, 0, 0);
    #2 chk("mid_reset", {hw_rvld, b_hw_rvld, conflict_cnt, b_conflict_cnt, hw_gnt, sw_grant},
           '0);
    tick();

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
